// File: rtl/fp_add_pkg.sv
// Shared definitions for the fp adder arbiter: widths, requester IDs and
// canonical IEEE-754 single-precision constants.
package fp_add_pkg;

  localparam int WIDTH = 32;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [31:0] FP_THREE = 32'h4040_0000;

endpackage

// File: rtl/fp_add_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit requester IDs, one entry per operation in flight.
// A pop on an empty FIFO is ignored; a push when full is only taken with a pop.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             push_id_i,
  input  logic             pop_i,
  output logic             head_id_o,
  output logic [PTR_W:0]   count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == '0);
  assign head_id_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one fp adder between requesters A and B; issued IDs
// are queued in order so each adder result is steered back to its requester.
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] a_opa,
  input  logic [WIDTH-1:0] a_opb,
  output logic             a_res_valid,
  output logic [WIDTH-1:0] a_res,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [WIDTH-1:0] b_opa,
  input  logic [WIDTH-1:0] b_opb,
  output logic             b_res_valid,
  output logic [WIDTH-1:0] b_res,
  output logic             add_start,
  output logic [WIDTH-1:0] add_opa,
  output logic [WIDTH-1:0] add_opb,
  input  logic             add_done,
  input  logic [WIDTH-1:0] add_sum,
  output logic             busy,
  output logic             err
);

  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);

  logic             can_issue;
  logic             grant_a;
  logic             grant_b;
  logic             handshake;
  logic             grant_id;
  logic             pop;
  logic             head_id;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PTR_W:0]   count;
  logic             busy_d;

  logic             rr_last_q;
  logic             add_start_q;
  logic [WIDTH-1:0] add_opa_q;
  logic [WIDTH-1:0] add_opb_q;
  logic             a_res_valid_q;
  logic             b_res_valid_q;
  logic [WIDTH-1:0] a_res_q;
  logic [WIDTH-1:0] b_res_q;
  logic             busy_q;
  logic             err_q;

  tag_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push_i    (handshake),
    .push_id_i (grant_id),
    .pop_i     (add_done),
    .head_id_o (head_id),
    .count_o   (count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign can_issue = ~fifo_full | add_done;
  assign pop       = add_done & ~fifo_empty;

  // Ready is also held low while reset is asserted.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset && can_issue) begin
      if (a_valid && b_valid) begin
        if (rr_last_q == REQ_B) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end else begin
      grant_a = 1'b0;
      grant_b = 1'b0;
    end
  end

  assign handshake = grant_a | grant_b;
  assign grant_id  = grant_b ? REQ_B : REQ_A;

  always_comb begin
    busy_d = 1'b0;
    if (handshake) begin
      busy_d = 1'b1;
    end else if (pop) begin
      busy_d = (count > CNT_ONE);
    end else begin
      busy_d = ~fifo_empty;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last_q     <= REQ_B;
      add_start_q   <= 1'b0;
      add_opa_q     <= '0;
      add_opb_q     <= '0;
      a_res_valid_q <= 1'b0;
      b_res_valid_q <= 1'b0;
      a_res_q       <= '0;
      b_res_q       <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      add_start_q   <= handshake;
      a_res_valid_q <= 1'b0;
      b_res_valid_q <= 1'b0;
      busy_q        <= busy_d;
      if (handshake) begin
        rr_last_q <= grant_id;
        add_opa_q <= grant_b ? b_opa : a_opa;
        add_opb_q <= grant_b ? b_opb : a_opb;
      end
      if (pop) begin
        if (head_id == REQ_B) begin
          b_res_q       <= add_sum;
          b_res_valid_q <= 1'b1;
        end else begin
          a_res_q       <= add_sum;
          a_res_valid_q <= 1'b1;
        end
      end
      if (add_done && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign add_start   = add_start_q;
  assign add_opa     = add_opa_q;
  assign add_opb     = add_opb_q;
  assign a_res_valid = a_res_valid_q;
  assign b_res_valid = b_res_valid_q;
  assign a_res       = a_res_q;
  assign b_res       = b_res_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: behavioural adder stand-in, result
// scoreboard, a vector table of single operations and directed corner cases.
module tb_fp_add_arbiter;
  import fp_add_pkg::*;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             a_valid, b_valid;
  logic             a_ready, b_ready;
  logic [WIDTH-1:0] a_opa, a_opb, b_opa, b_opb;
  logic             a_res_valid, b_res_valid;
  logic [WIDTH-1:0] a_res, b_res;
  logic             add_start;
  logic [WIDTH-1:0] add_opa, add_opb;
  logic             add_done;
  logic [WIDTH-1:0] add_sum;
  logic             busy, err;

  always #5 clk = ~clk;

  fp_add_arbiter #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opa(a_opa), .a_opb(a_opb),
    .a_res_valid(a_res_valid), .a_res(a_res),
    .b_valid(b_valid), .b_ready(b_ready), .b_opa(b_opa), .b_opb(b_opb),
    .b_res_valid(b_res_valid), .b_res(b_res),
    .add_start(add_start), .add_opa(add_opa), .add_opb(add_opb),
    .add_done(add_done), .add_sum(add_sum),
    .busy(busy), .err(err)
  );

  typedef struct { logic id; logic [31:0] sum; } exp_t;
  typedef struct { int due; logic [31:0] sum; } pend_t;
  typedef struct { logic id; logic [31:0] opa; logic [31:0] opb; logic [31:0] res; } vec_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];
  exp_t  mon_e;
  pend_t model_p;
  vec_t  vecs[6];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat = 3;
  bit hold_done = 1'b0;
  int release_cnt = 0;
  bit spurious_req = 1'b0;

  // Adder stand-in: real sums for the canonical values, an asymmetric mix otherwise.
  function automatic logic [31:0] model_sum(input logic [31:0] x, input logic [31:0] y);
    if (x == FP_ONE && y == FP_TWO) return FP_THREE;
    if (x == FP_TWO && y == FP_ONE) return FP_THREE;
    if (x == FP_ONE && y == FP_ONE) return FP_TWO;
    return x + {y[15:0], y[31:16]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Adder model: latches issued operands, answers in order after lat cycles.
  initial begin
    add_done = 1'b0;
    add_sum  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset !== 1'b1) begin
        pend_q.delete();
        add_done = 1'b0;
      end else begin
        if (add_start) begin
          model_p.due = cyc + lat;
          model_p.sum = model_sum(add_opa, add_opb);
          pend_q.push_back(model_p);
        end
        add_done = 1'b0;
        if (spurious_req) begin
          add_done     = 1'b1;
          add_sum      = 32'hDEAD_BEEF;
          spurious_req = 1'b0;
        end else if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
                     (!hold_done || release_cnt > 0)) begin
          add_done = 1'b1;
          add_sum  = pend_q[0].sum;
          void'(pend_q.pop_front());
          if (hold_done) release_cnt--;
        end
      end
    end
  end

  // Scoreboard: record handshakes, compare every result strobe in order.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset === 1'b1) begin
        check("ready_onehot", {31'd0, a_ready & b_ready}, 32'd0);
        if (a_valid && a_ready) begin
          mon_e.id = REQ_A; mon_e.sum = model_sum(a_opa, a_opb); exp_q.push_back(mon_e);
        end
        if (b_valid && b_ready) begin
          mon_e.id = REQ_B; mon_e.sum = model_sum(b_opa, b_opb); exp_q.push_back(mon_e);
        end
        if (a_res_valid || b_res_valid) begin
          if (a_res_valid && b_res_valid) begin
            check("res_both_strobes", 32'd1, 32'd0);
          end else if (exp_q.size() == 0) begin
            check("res_unexpected", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("res_port", {31'd0, b_res_valid}, {31'd0, mon_e.id});
            check("res_value", b_res_valid ? b_res : a_res, mon_e.sum);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    hold_done = 1'b0; release_cnt = 0; spurious_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    a_valid = 1'b0; b_valid = 1'b0; hold_done = 1'b0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk); #3;
    check("drain_pending", exp_q.size(), 32'd0);
    check("drain_busy", busy, 1'b0);
  endtask

  task automatic wait_res(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk); #1;
      if (a_res_valid || b_res_valid) got = 1'b1;
    end
    check("res_arrived", got, 1'b1);
  endtask

  task automatic issue(input logic id, input logic [31:0] x, input logic [31:0] y);
    bit got = 1'b0;
    @(negedge clk);
    if (id == REQ_A) begin a_valid = 1'b1; a_opa = x; a_opb = y; end
    else begin b_valid = 1'b1; b_opa = x; b_opb = y; end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if ((id == REQ_A) ? a_ready : b_ready) got = 1'b1;
      else @(negedge clk);
    end
    check("issue_ready", got, 1'b1);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  initial begin
    bit got;
    int hs;
    logic exp_id;
    logic a_hs, b_hs;

    vecs[0] = '{REQ_A, FP_ONE, FP_TWO, FP_THREE};
    vecs[1] = '{REQ_B, FP_TWO, FP_ONE, FP_THREE};
    vecs[2] = '{REQ_A, FP_ONE, FP_ONE, FP_TWO};
    vecs[3] = '{REQ_B, FP_ONE, FP_ONE, FP_TWO};
    vecs[4] = '{REQ_A, FP_TWO, FP_ONE, FP_THREE};
    vecs[5] = '{REQ_B, FP_ONE, FP_TWO, FP_THREE};

    reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1;
    a_opa = FP_ONE; a_opb = FP_TWO; b_opa = FP_TWO; b_opb = FP_ONE;
    @(negedge clk); #1;
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_add_start", add_start, 1'b0);
    check("rst_add_opa", add_opa, 32'd0);
    check("rst_res_valid", {30'd0, a_res_valid, b_res_valid}, 32'd0);
    check("rst_a_res", a_res, 32'd0);
    check("rst_busy_err", {30'd0, busy, err}, 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single A operation, latency 3.
    lat = 3;
    @(negedge clk);
    a_valid = 1'b1; a_opa = FP_ONE; a_opb = FP_TWO;
    #1;
    check("t1_a_ready", a_ready, 1'b1);
    check("t1_add_start_early", add_start, 1'b0);
    @(negedge clk);
    a_valid = 1'b0;
    #1;
    check("t1_add_start", add_start, 1'b1);
    check("t1_add_opa", add_opa, FP_ONE);
    check("t1_add_opb", add_opb, FP_TWO);
    check("t1_busy", busy, 1'b1);
    @(negedge clk); #1;
    check("t1_start_pulse", add_start, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (add_done) got = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("t1_add_done", got, 1'b1);
    @(negedge clk); #1;
    check("t1_a_res_valid", a_res_valid, 1'b1);
    check("t1_a_res", a_res, FP_THREE);
    check("t1_b_res_valid", b_res_valid, 1'b0);
    @(negedge clk); #1;
    check("t1_strobe_len", a_res_valid, 1'b0);
    check("t1_res_hold", a_res, FP_THREE);
    check("t1_idle", busy, 1'b0);

    // Vector table: one operation per record, checked against the table result.
    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].id, vecs[v].opa, vecs[v].opb);
      wait_res(20, got);
      check("vec_port", {31'd0, b_res_valid}, {31'd0, vecs[v].id});
      check("vec_res", (vecs[v].id == REQ_B) ? b_res : a_res, vecs[v].res);
    end
    drain();

    // Both valid continuously: alternate starting with A.
    do_reset();
    lat = 2;
    @(negedge clk);
    a_valid = 1'b1; b_valid = 1'b1;
    a_opa = $urandom; a_opb = $urandom; b_opa = $urandom; b_opb = $urandom;
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_id = (i % 2 == 0) ? REQ_A : REQ_B;
      check("alt_a_ready", a_ready, exp_id == REQ_A);
      check("alt_b_ready", b_ready, exp_id == REQ_B);
      a_hs = a_ready; b_hs = b_ready;
      @(negedge clk);
      if (a_hs) begin a_opa = $urandom; a_opb = $urandom; end
      if (b_hs) begin b_opa = $urandom; b_opb = $urandom; end
    end
    drain();

    // Fill the FIFO with add_done withheld, then release one result.
    do_reset();
    lat = 1; hold_done = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_opa = $urandom; a_opb = $urandom;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      a_hs = a_ready;
      if (a_hs) hs++;
      @(negedge clk);
      if (a_hs) begin a_opa = $urandom; a_opb = $urandom; end
    end
    #1;
    check("fill_handshakes", hs, 32'd4);
    check("fill_a_ready", a_ready, 1'b0);
    check("fill_busy", busy, 1'b1);
    release_cnt = 1;
    @(negedge clk); #1;
    check("fill_release_done", add_done, 1'b1);
    check("fill_release_ready", a_ready, 1'b1);
    @(negedge clk);
    a_opa = $urandom; a_opb = $urandom;
    #1;
    check("fill_still_full", a_ready, 1'b0);
    check("fill_busy2", busy, 1'b1);
    drain();

    // Spurious add_done with nothing in flight.
    do_reset();
    @(negedge clk); #1;
    spurious_req = 1'b1;
    @(negedge clk); #1;
    check("sp_done_seen", add_done, 1'b1);
    @(negedge clk); #1;
    check("sp_err", err, 1'b1);
    check("sp_no_strobe", {30'd0, a_res_valid, b_res_valid}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("sp_err_sticky", err, 1'b1);
    reset = 1'b0;
    #1;
    check("sp_err_async_clr", err, 1'b0);
    @(negedge clk);
    exp_q.delete();
    reset = 1'b1;

    // Reset while three operations are in flight.
    lat = 6;
    @(negedge clk);
    a_valid = 1'b1; a_opa = $urandom; a_opb = $urandom;
    hs = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_ready) hs++;
      @(negedge clk);
      a_opa = $urandom; a_opb = $urandom;
    end
    a_valid = 1'b0;
    check("mid_handshakes", hs, 32'd3);
    #1;
    check("mid_busy", busy, 1'b1);
    reset = 1'b0;
    a_valid = 1'b1;
    #1;
    check("mid_rst_ready", a_ready, 1'b0);
    check("mid_rst_start", add_start, 1'b0);
    check("mid_rst_opa", add_opa, 32'd0);
    check("mid_rst_busy_err", {30'd0, busy, err}, 32'd0);
    check("mid_rst_res", {30'd0, a_res_valid, b_res_valid}, 32'd0);
    @(negedge clk);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    a_opa = FP_ONE; a_opb = FP_ONE;
    #1;
    check("mid_ready_back", a_ready, 1'b1);
    @(negedge clk);
    a_valid = 1'b0;
    wait_res(20, got);
    check("mid_res", a_res, FP_TWO);
    drain();
    check("mid_no_stale_err", err, 1'b0);

    // Only B requesting with rr_last = B: granted every cycle.
    do_reset();
    lat = 2;
    @(negedge clk);
    b_valid = 1'b1; b_opa = $urandom; b_opb = $urandom;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bonly_b_ready", b_ready, 1'b1);
      check("bonly_a_ready", a_ready, 1'b0);
      @(negedge clk);
      b_opa = $urandom; b_opb = $urandom;
    end
    drain();

    // Random traffic, requesters hold until accepted.
    a_hs = 1'b0; b_hs = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!a_valid || a_hs) begin
        a_valid = 1'($urandom_range(0, 1)); a_opa = $urandom; a_opb = $urandom;
      end
      if (!b_valid || b_hs) begin
        b_valid = 1'($urandom_range(0, 1)); b_opa = $urandom; b_opb = $urandom;
      end
      if (i % 10 == 0) lat = $urandom_range(1, 6);
      #1;
      a_hs = a_valid & a_ready;
      b_hs = b_valid & b_ready;
    end
    @(negedge clk);
    drain();
    check("final_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
